// File: rtl/gb_inst_fetch.sv
// Game Boy instruction fetch: reads opcode/immediate bytes, tracks the CB prefix, owns the PC.
module gb_inst_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_start,
   input  logic        inst_done,
   input  logic [1:0]  imm_len,
   input  logic        pc_load,
   input  logic [15:0] pc_load_value,
   input  logic        mem_ready,
   input  logic [7:0]  mem_data_in,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   output logic [15:0] pc,
   output logic [7:0]  inst_buffer,
   output logic [15:0] imm16,
   output logic        inst_valid,
   output logic        cb_active,
   output logic        toggle_cb
);

   localparam logic [7:0] CB_PREFIX = 8'hCB;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_OP,
      FETCH_CB,
      DECODE,
      FETCH_IMM_LO,
      FETCH_IMM_HI,
      READY
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] pc_nxt, imm16_nxt, pc_inc;
   logic [7:0]  inst_buffer_nxt;
   logic        cb_active_nxt, toggle_cb_nxt, need_hi, need_hi_nxt;
   logic        mem_rd_nxt, inst_valid_nxt, accept;

   // The bus address is the PC itself; a byte lands when a request meets ready.
   assign mem_addr = pc;
   assign accept   = mem_rd & mem_ready;
   assign pc_inc   = pc + 16'd1;

   // State and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inst_buffer <= 8'h00;
         imm16       <= 16'h0000;
         need_hi     <= 1'b0;
         mem_rd      <= 1'b0;
         inst_valid  <= 1'b0;
         cb_active   <= 1'b0;
         toggle_cb   <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         inst_buffer <= inst_buffer_nxt;
         imm16       <= imm16_nxt;
         need_hi     <= need_hi_nxt;
         mem_rd      <= mem_rd_nxt;
         inst_valid  <= inst_valid_nxt;
         cb_active   <= cb_active_nxt;
         toggle_cb   <= toggle_cb_nxt;
      end
   end

   // Next-state and next-output decode; a PC load preempts any byte accept.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      inst_buffer_nxt = inst_buffer;
      imm16_nxt       = imm16;
      need_hi_nxt     = need_hi;
      cb_active_nxt   = cb_active;
      toggle_cb_nxt   = 1'b0;

      if (pc_load) begin
         pc_nxt    = pc_load_value;
         state_nxt = IDLE;
         if (cb_active) begin
            cb_active_nxt = 1'b0;
            toggle_cb_nxt = 1'b1;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (fetch_start) state_nxt = FETCH_OP;
            end
            FETCH_OP: begin
               if (accept) begin
                  pc_nxt = pc_inc;
                  if (mem_data_in == CB_PREFIX) begin
                     state_nxt     = FETCH_CB;
                     cb_active_nxt = 1'b1;
                     toggle_cb_nxt = 1'b1;
                  end else begin
                     inst_buffer_nxt = mem_data_in;
                     imm16_nxt       = 16'h0000;
                     state_nxt       = DECODE;
                  end
               end
            end
            FETCH_CB: begin
               if (accept) begin
                  pc_nxt          = pc_inc;
                  inst_buffer_nxt = mem_data_in;
                  state_nxt       = READY;
               end
            end
            DECODE: begin
               need_hi_nxt = imm_len[1];
               state_nxt   = (imm_len == 2'd0) ? READY : FETCH_IMM_LO;
            end
            FETCH_IMM_LO: begin
               if (accept) begin
                  pc_nxt          = pc_inc;
                  imm16_nxt[7:0]  = mem_data_in;
                  state_nxt       = need_hi ? FETCH_IMM_HI : READY;
               end
            end
            FETCH_IMM_HI: begin
               if (accept) begin
                  pc_nxt          = pc_inc;
                  imm16_nxt[15:8] = mem_data_in;
                  state_nxt       = READY;
               end
            end
            READY: begin
               if (inst_done) begin
                  if (cb_active) begin
                     cb_active_nxt = 1'b0;
                     toggle_cb_nxt = 1'b1;
                  end
                  state_nxt = fetch_start ? FETCH_OP : IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      mem_rd_nxt     = (state_nxt == FETCH_OP) || (state_nxt == FETCH_CB) ||
                       (state_nxt == FETCH_IMM_LO) || (state_nxt == FETCH_IMM_HI);
      inst_valid_nxt = (state_nxt == READY);
   end

endmodule

// File: tb/tb_gb_inst_fetch.sv
// Self-checking bench for gb_inst_fetch: memory/bus responder plus transaction-level expectations.
module tb_gb_inst_fetch;

   logic        clock = 1'b0;
   logic        reset, fetch_start, inst_done, pc_load, mem_ready;
   logic [1:0]  imm_len;
   logic [15:0] pc_load_value;
   logic [7:0]  mem_data_in;
   logic        mem_rd, inst_valid, cb_active, toggle_cb;
   logic [15:0] mem_addr, pc, imm16;
   logic [7:0]  inst_buffer;

   logic [7:0]  mem [0:65535];
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_pc;
   bit          prev_cb, in_ready, stopped;
   int          wait_per_byte = 0;
   int          wcnt = 0;
   bit          force_ready = 1'b0;

   gb_inst_fetch dut (
      .clock(clock), .reset(reset), .fetch_start(fetch_start), .inst_done(inst_done),
      .imm_len(imm_len), .pc_load(pc_load), .pc_load_value(pc_load_value),
      .mem_ready(mem_ready), .mem_data_in(mem_data_in), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .pc(pc), .inst_buffer(inst_buffer), .imm16(imm16),
      .inst_valid(inst_valid), .cb_active(cb_active), .toggle_cb(toggle_cb)
   );

   always #5 clock = ~clock;

   assign mem_data_in = mem[mem_addr];

   // Bus responder: w wait cycles before each byte; random ready while no request is pending.
   always @(negedge clock) begin
      if (force_ready) begin
         mem_ready = 1'b1;
      end else if (mem_rd) begin
         if (wcnt < wait_per_byte) begin
            mem_ready = 1'b0;
            wcnt++;
         end else begin
            mem_ready = 1'b1;
            wcnt = 0;
         end
      end else begin
         mem_ready = 1'($urandom);
         wcnt = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_pc", 32'(pc), 32'h0000);
      check("rst_inst_buffer", 32'(inst_buffer), 32'h00);
      check("rst_imm16", 32'(imm16), 32'h0000);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_cb_active", 32'(cb_active), 32'd0);
      check("rst_toggle_cb", 32'(toggle_cb), 32'd0);
      exp_pc = 16'h0000; prev_cb = 1'b0; in_ready = 1'b0;
   endtask

   // One instruction fetch; latency and results computed from byte counts and wait cycles.
   task automatic fetch(input logic [7:0] op, input logic [1:0] il, input int w, input bit b2b,
                        input int stop_at, input logic [7:0] b1, input logic [7:0] b2);
      logic [15:0] a1, a2, exp_imm;
      logic [7:0]  exp_ib;
      int          n, lat, len, k, tog_a, tog_b;
      bit          is_cb, got;
      is_cb = (op == 8'hCB);
      a1 = exp_pc + 16'd1;
      a2 = exp_pc + 16'd2;
      mem[exp_pc] = op; mem[a1] = b1; mem[a2] = b2;
      n = (il == 2'd0) ? 0 : (il == 2'd1) ? 1 : 2;
      if (is_cb) begin
         exp_ib = b1; exp_imm = 16'h0000; len = 2; lat = 3 + 2 * w;
      end else begin
         exp_ib = op; len = 1 + n; lat = 3 + n + (1 + n) * w;
         exp_imm = (n == 0) ? 16'h0000 : (n == 1) ? {8'h00, b1} : {b2, b1};
      end
      tog_a = (b2b && prev_cb) ? 1 : -1;
      tog_b = is_cb ? 2 + w : -1;
      wait_per_byte = w; imm_len = il;
      fetch_start = 1'b1; inst_done = b2b;
      stopped = 1'b0; k = 0; got = 1'b0;
      while (!got && k < lat + 6) begin
         @(posedge clock); #1;
         fetch_start = 1'b0; inst_done = 1'b0; k++;
         if (k == 1) begin
            check("mem_rd_c1", 32'(mem_rd), 32'd1);
            if (b2b) check("b2b_cb_cleared", 32'(cb_active), 32'd0);
         end
         check("toggle_cb", 32'(toggle_cb), 32'((k == tog_a) || (k == tog_b)));
         if (k == stop_at) begin
            stopped = 1'b1;
            in_ready = 1'b0;
            return;
         end
         got = inst_valid;
      end
      check("latency", 32'(k), 32'(lat));
      exp_pc = exp_pc + 16'(len);
      check("pc", 32'(pc), 32'(exp_pc));
      check("inst_buffer", 32'(inst_buffer), 32'(exp_ib));
      if (!is_cb) check("imm16", 32'(imm16), 32'(exp_imm));
      check("cb_active", 32'(cb_active), 32'(is_cb));
      check("ready_mem_rd", 32'(mem_rd), 32'd0);
      prev_cb = is_cb; in_ready = 1'b1;
   endtask

   task automatic hold_check();
      fetch_start = 1'b1; inst_done = 1'b0;
      @(posedge clock); #1;
      fetch_start = 1'b0;
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_mem_rd", 32'(mem_rd), 32'd0);
      check("hold_pc", 32'(pc), 32'(exp_pc));
   endtask

   task automatic finish_inst();
      inst_done = 1'b1; fetch_start = 1'b0;
      @(posedge clock); #1;
      inst_done = 1'b0;
      check("done_valid", 32'(inst_valid), 32'd0);
      check("done_toggle", 32'(toggle_cb), 32'(prev_cb));
      check("done_cb_active", 32'(cb_active), 32'd0);
      check("done_mem_rd", 32'(mem_rd), 32'd0);
      prev_cb = 1'b0; in_ready = 1'b0;
      @(posedge clock); #1;
      check("toggle_single", 32'(toggle_cb), 32'd0);
   endtask

   task automatic load(input logic [15:0] v);
      pc_load = 1'b1; pc_load_value = v;
      @(posedge clock); #1;
      pc_load = 1'b0;
      check("load_pc", 32'(pc), 32'(v));
      check("load_valid", 32'(inst_valid), 32'd0);
      check("load_mem_rd", 32'(mem_rd), 32'd0);
      check("load_toggle", 32'(toggle_cb), 32'(prev_cb));
      check("load_cb_active", 32'(cb_active), 32'd0);
      exp_pc = v; prev_cb = 1'b0; in_ready = 1'b0;
      @(posedge clock); #1;
      check("load_toggle_single", 32'(toggle_cb), 32'd0);
      check("load_idle_rd", 32'(mem_rd), 32'd0);
      check("load_pc_stable", 32'(pc), 32'(v));
   endtask

   initial begin
      reset = 1'b1; fetch_start = 1'b0; inst_done = 1'b0; pc_load = 1'b0;
      pc_load_value = 16'h0000; imm_len = 2'd0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      check_reset_vals();

      // Opcode 0x00 at 0x0000, no immediates.
      fetch(8'h00, 2'd0, 0, 1'b0, -1, 8'h11, 8'h22);
      finish_inst();

      // Two immediates, zero wait then two waits per byte.
      fetch(8'h01, 2'd2, 0, 1'b0, -1, 8'h34, 8'h12);
      hold_check();
      finish_inst();
      fetch(8'h01, 2'd2, 2, 1'b0, -1, 8'h34, 8'h12);
      finish_inst();

      // CB-prefixed instruction.
      fetch(8'hCB, 2'd2, 0, 1'b0, -1, 8'h37, 8'h00);
      finish_inst();

      // PC wrap from 0xFFFF.
      load(16'hFFFF);
      fetch(8'h00, 2'd0, 0, 1'b0, -1, 8'h55, 8'h66);
      check("pc_wrap", 32'(pc), 32'h0000);
      finish_inst();

      // PC load during the low immediate fetch with the bus ready.
      fetch(8'h21, 2'd2, 0, 1'b0, 3, 8'hAA, 8'hBB);
      force_ready = 1'b1;
      load(16'hC000);
      force_ready = 1'b0;
      check("load_no_accept_imm", 32'(imm16), 32'h0000);

      // PC load while a CB instruction is held in READY.
      fetch(8'hCB, 2'd1, 1, 1'b0, -1, 8'h5A, 8'h00);
      load(16'h0100);

      // Reset in the high immediate fetch.
      fetch(8'h01, 2'd2, 0, 1'b0, 4, 8'h77, 8'h88);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check_reset_vals();

      // Randomized mix of instructions, back-to-back starts, holds and loads.
      for (int t = 0; t < 60; t++) begin
         bit          b2b;
         logic [7:0]  op;
         b2b = in_ready && ($urandom_range(0, 1) == 1);
         if (in_ready && !b2b) begin
            if ($urandom_range(0, 3) == 0) hold_check();
            if ($urandom_range(0, 5) == 0) load(16'($urandom));
            else finish_inst();
         end
         op = 8'($urandom);
         if (op == 8'hCB) op = 8'h3E;
         if ($urandom_range(0, 3) == 0) op = 8'hCB;
         fetch(op, 2'($urandom), int'($urandom_range(0, 2)), b2b, -1,
               8'($urandom), 8'($urandom));
      end
      finish_inst();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
